// File: rtl/layer_output_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_output_serializer_pkg
// Purpose  : Shared constants for the layer output serializer: FSM state
//            encoding and buffer sizing helper.
// Revision : 1.0 - initial release
// ============================================================================
package layer_output_serializer_pkg;

  // Two-state burst controller encoding
  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_shift = 1'b1;

  // Words held back after word 0 goes straight to the output. A single
  // neuron needs no buffer, but a one-entry array keeps the declaration legal.
  function automatic int buf_depth(input int n);
    return (n > 1) ? (n - 1) : 1;
  endfunction

endpackage : layer_output_serializer_pkg
`default_nettype wire

// File: rtl/layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module   : layer_output_serializer
// Purpose  : Captures all neuron outputs of a layer on their common valid
//            pulse and streams them one word per clock, neuron 0 first, onto
//            the next layer's shared input bus. No flow control.
// Revision : 1.0 - initial release
// ============================================================================
module layer_output_serializer
  import layer_output_serializer_pkg::*;
#(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons-1:0]           x_valid,
  input  logic [numNeurons*dataWidth-1:0] x_in,
  output logic [dataWidth-1:0]            data_out,
  output logic                            data_out_valid,
  output logic                            busy,
  output logic                            overrun,
  output logic                            skew_err
);

  localparam int                 c_cnt_w     = $clog2(numNeurons + 1);
  localparam int                 c_buf_depth = buf_depth(numNeurons);
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(numNeurons);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic               c_multi     = (numNeurons > 1);

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [dataWidth-1:0] r_buf     [c_buf_depth];
  logic [dataWidth-1:0] w_buf_nxt [c_buf_depth];
  logic [dataWidth-1:0] r_data;
  logic [dataWidth-1:0] w_data_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 r_overrun;
  logic                 r_skew;

  logic w_cap;
  logic w_partial;
  logic w_last;
  logic w_load;
  logic w_drop;

  // Capture qualification: all neurons must agree; a partial pulse is a skew
  assign w_cap     = &x_valid;
  assign w_partial = (|x_valid) & ~w_cap;
  // Last beat of the burst is on the output; a new capture may chain on now
  assign w_last    = (r_state == c_st_shift) && (r_cnt == c_cnt_last);
  assign w_load    = w_cap && ((r_state == c_st_idle) || w_last);
  assign w_drop    = w_cap && (r_state == c_st_shift) && !w_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: enter SHIFT on a multi-word capture, leave after the last beat
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_cap && c_multi) w_state_nxt = c_st_shift;
      end
      c_st_shift: begin
        if (w_last) w_state_nxt = (w_cap && c_multi) ? c_st_shift : c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Datapath next values: load word 0 + buffer, shift buffer, or go quiet
  always_comb begin
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    for (int i = 0; i < c_buf_depth; i++) w_buf_nxt[i] = r_buf[i];

    if (w_load) begin
      w_data_nxt  = x_in[0 +: dataWidth];
      w_valid_nxt = 1'b1;
      w_cnt_nxt   = c_cnt_one;
      for (int i = 0; i < numNeurons - 1; i++) begin
        w_buf_nxt[i] = x_in[(i+1)*dataWidth +: dataWidth];
      end
    end else if ((r_state == c_st_shift) && !w_last) begin
      w_data_nxt  = r_buf[0];
      w_valid_nxt = 1'b1;
      w_cnt_nxt   = r_cnt + c_cnt_one;
      for (int i = 0; i < c_buf_depth - 1; i++) w_buf_nxt[i] = r_buf[i+1];
    end else begin
      w_data_nxt  = '0;
      w_valid_nxt = 1'b0;
      w_cnt_nxt   = '0;
    end
  end

  // Output, counter and sticky-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
      r_skew    <= 1'b0;
    end else begin
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_drop)    r_overrun <= 1'b1;
      if (w_partial) r_skew    <= 1'b1;
    end
  end

  // Buffer needs no reset: its contents are only read after a load
  always_ff @(posedge clk) begin
    for (int i = 0; i < c_buf_depth; i++) r_buf[i] <= w_buf_nxt[i];
  end

  assign data_out       = r_data;
  assign data_out_valid = r_valid;
  assign busy           = (r_state == c_st_shift);
  assign overrun        = r_overrun;
  assign skew_err       = r_skew;

endmodule : layer_output_serializer
`default_nettype wire
